// File: rtl/dmem_access_unit.sv
// Load/store unit between the memory stage and a word-wide, little-endian data memory.
// Loads read a word and extract a lane; sub-word stores read, merge and write back.
module dmem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        MERGE   = 3'd3,
        RESP    = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    function automatic logic bad_access(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: res = {{24{sgn & b[7]}}, b};
            SZ_HALF: res = {{16{sgn & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic [15:0] wd);
        logic [31:0] res;
        res = word;
        case (size)
            SZ_BYTE: res[{lane, 3'b000} +: 8]    = wd[7:0];
            SZ_HALF: res[{lane[1], 4'b0000} +: 16] = wd;
            default: res = word;
        endcase
        return res;
    endfunction

    state_t      state_r;
    logic        store_r;
    logic [1:0]  size_r;
    logic        signed_r;
    logic [1:0]  lane_r;
    logic [15:0] wdata_r;
    logic        req_err_s;
    logic        accept_s;

    assign req_err_s = bad_access(req_size, req_addr[1:0]);
    assign accept_s  = req_valid & req_ready;

    // Request FSM; every output is a register loaded for the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            store_r    <= 1'b0;
            size_r     <= 2'b00;
            signed_r   <= 1'b0;
            lane_r     <= 2'b00;
            wdata_r    <= 16'h0000;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        store_r   <= req_store;
                        size_r    <= req_size;
                        signed_r  <= req_signed;
                        lane_r    <= req_addr[1:0];
                        wdata_r   <= req_wdata[15:0];
                        req_ready <= 1'b0;
                        if (req_err_s) begin
                            state_r    <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= '0;
                        end else begin
                            state_r  <= ISSUE;
                            mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            // Full-word stores write straight away; no read is needed.
                            if (req_store && (req_size == SZ_WORD)) begin
                                mem_we    <= 1'b1;
                                mem_wdata <= req_wdata;
                            end else begin
                                mem_we    <= 1'b0;
                                mem_wdata <= '0;
                            end
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (store_r && (size_r == SZ_WORD)) begin
                        state_r    <= RESP;
                        resp_valid <= 1'b1;
                        resp_data  <= '0;
                        resp_err   <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_addr   <= '0;
                        mem_wdata  <= '0;
                    end else begin
                        state_r <= CAPTURE;
                        mem_we  <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (store_r) begin
                        state_r   <= MERGE;
                        mem_wdata <= store_merge(mem_rdata, size_r, lane_r, wdata_r);
                        mem_we    <= 1'b1;
                    end else begin
                        state_r    <= RESP;
                        resp_valid <= 1'b1;
                        resp_data  <= load_extract(mem_rdata, size_r, lane_r, signed_r);
                        resp_err   <= 1'b0;
                        mem_addr   <= '0;
                    end
                end
                MERGE: begin
                    state_r    <= RESP;
                    resp_valid <= 1'b1;
                    resp_data  <= '0;
                    resp_err   <= 1'b0;
                    mem_we     <= 1'b0;
                    mem_addr   <= '0;
                    mem_wdata  <= '0;
                end
                RESP: begin
                    state_r    <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_data  <= '0;
                    resp_err   <= 1'b0;
                    mem_we     <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_data  <= '0;
                    resp_err   <= 1'b0;
                    mem_addr   <= '0;
                    mem_wdata  <= '0;
                    mem_we     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a word-wide synchronous memory model
// and a queue of expected responses.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    dmem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Memory: synchronous read; a write latched at one edge commits at the next.
    logic [31:0] mem [0:15];
    logic        we_q = 1'b0;
    logic [3:0]  waddr_q = 4'd0;
    logic [31:0] wdata_q = 32'd0;

    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr[5:2]];
        we_q      <= mem_we;
        waddr_q   <= mem_addr[5:2];
        wdata_q   <= mem_wdata;
        if (we_q) mem[waddr_q] <= wdata_q;
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   we_cycles;
    int   we_last;
    int   waited;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic issue(input logic st, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] ed, input logic ee, input int el,
                         input logic hold);
        req_store  = st;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        exp_q.push_back('{ed, ee, el});
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("ready_before_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag);
        exp_t e;
        int   lat;
        int   rdy_seen;
        e = exp_q.pop_front();
        we_cycles = 0;
        we_last   = 0;
        rdy_seen  = 0;
        for (lat = 1; lat < 12; lat++) begin
            if (mem_we) begin
                we_cycles++;
                we_last = lat;
            end
            if (req_ready) rdy_seen++;
            if (resp_valid) break;
            @(negedge clk);
        end
        check({tag, "_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(e.lat));
        check({tag, "_data"}, resp_data, e.data);
        check({tag, "_err"}, 32'(resp_err), 32'(e.err));
        check({tag, "_busy"}, 32'(rdy_seen), 32'd0);
    endtask

    exp_t drop;
    int   pulses;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        #12;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rvalid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_data, 32'd0);
        check("rst_rerr", 32'(resp_err), 32'd0);
        check("rst_maddr", mem_addr, 32'd0);
        check("rst_mwdata", mem_wdata, 32'd0);
        check("rst_mwe", 32'(mem_we), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Word store then word load.
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h8877_6655, 32'd0, 1'b0, 2, 1'b0);
        wait_resp("wst");
        check("wst_we_cnt", 32'(we_cycles), 32'd1);
        check("wst_we_at", 32'(we_last), 32'd1);
        @(negedge clk);
        check("wst_mem", mem[4], 32'h8877_6655);
        check("idle_rdata", resp_data, 32'd0);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'h8877_6655, 1'b0, 3, 1'b0);
        wait_resp("wld");
        check("wld_we_cnt", 32'(we_cycles), 32'd0);

        // Sub-word loads, signed and unsigned.
        issue(1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 32'hFFFF_FF88, 1'b0, 3, 1'b0);
        wait_resp("lb_s");
        issue(1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 32'h0000_0088, 1'b0, 3, 1'b0);
        wait_resp("lb_u");
        issue(1'b0, 2'b01, 1'b1, 32'h12, 32'd0, 32'hFFFF_8877, 1'b0, 3, 1'b0);
        wait_resp("lh_s");
        issue(1'b0, 2'b01, 1'b0, 32'h10, 32'd0, 32'h0000_6655, 1'b0, 3, 1'b0);
        wait_resp("lh_u");
        issue(1'b0, 2'b00, 1'b1, 32'h10, 32'd0, 32'h0000_0055, 1'b0, 3, 1'b0);
        wait_resp("lb_pos");

        // Sub-word stores via read-modify-write; upper wdata bits must be ignored.
        issue(1'b1, 2'b00, 1'b0, 32'h11, 32'hDEAD_BEAB, 32'd0, 1'b0, 4, 1'b0);
        wait_resp("sb");
        check("sb_we_cnt", 32'(we_cycles), 32'd1);
        check("sb_we_at", 32'(we_last), 32'd3);
        @(negedge clk);
        check("sb_mem", mem[4], 32'h8877_AB55);
        issue(1'b1, 2'b01, 1'b0, 32'h12, 32'hCAFE_1234, 32'd0, 1'b0, 4, 1'b0);
        wait_resp("sh");
        check("sh_we_cnt", 32'(we_cycles), 32'd1);
        check("sh_we_at", 32'(we_last), 32'd3);
        @(negedge clk);
        check("sh_mem", mem[4], 32'h1234_AB55);

        // Errors: misaligned half, misaligned word store, reserved size.
        issue(1'b0, 2'b01, 1'b1, 32'h11, 32'd0, 32'd0, 1'b1, 1, 1'b0);
        wait_resp("err_lh");
        check("err_lh_we", 32'(we_cycles), 32'd0);
        issue(1'b1, 2'b10, 1'b0, 32'h16, 32'hFFFF_FFFF, 32'd0, 1'b1, 1, 1'b0);
        wait_resp("err_sw");
        check("err_sw_we", 32'(we_cycles), 32'd0);
        issue(1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 32'd0, 1'b1, 1, 1'b0);
        wait_resp("err_sz");
        check("err_sz_we", 32'(we_cycles), 32'd0);
        @(negedge clk);
        check("err_mem4", mem[4], 32'h1234_AB55);
        check("err_mem5", mem[5], 32'd0);

        // Back-to-back: valid stays high; load must wait for the IDLE after RESP.
        issue(1'b1, 2'b00, 1'b0, 32'h10, 32'h0000_0077, 32'd0, 1'b0, 4, 1'b1);
        req_store = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h10;
        req_wdata = 32'd0;
        wait_resp("b2b_st");
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'h1234_AB77, 1'b0, 3, 1'b0);
        check("b2b_wait", 32'(waited), 32'd1);
        wait_resp("b2b_ld");

        // Reset during CAPTURE of a half store: request dropped, memory untouched.
        issue(1'b1, 2'b01, 1'b0, 32'h10, 32'h0000_5555, 32'd0, 1'b0, 4, 1'b0);
        drop = exp_q.pop_front();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_ready", 32'(req_ready), 32'd1);
        check("mid_rvalid", 32'(resp_valid), 32'd0);
        check("mid_rdata", resp_data, 32'd0);
        check("mid_rerr", 32'(resp_err), 32'd0);
        check("mid_maddr", mem_addr, 32'd0);
        check("mid_mwdata", mem_wdata, 32'd0);
        check("mid_mwe", 32'(mem_we), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        check("mid_no_resp", 32'(pulses), 32'd0);
        check("mid_mem", mem[4], 32'h1234_AB77);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'h1234_AB77, 1'b0, 3, 1'b0);
        wait_resp("post_rst_ld");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
